// File: rtl/ekf_pkg.sv
// Shared constants for the EKF datapath: stage one-hot codes, per-stage
// word counts, temp-buffer base addresses and the responder FSM encoding.
package ekf_pkg;

  localparam logic [2:0] STG_PRD = 3'b001;
  localparam logic [2:0] STG_NEW = 3'b010;
  localparam logic [2:0] STG_UPD = 3'b100;

  localparam int WORDS_PRD = 3;
  localparam int WORDS_LM  = 2;
  localparam int BASE_PRD  = 0;
  localparam int BASE_LM   = 3;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    WRITE,
    DONE
  } nl_state_e;

  function automatic logic is_onehot3(input logic [2:0] v);
    return (v == STG_PRD) || (v == STG_NEW) || (v == STG_UPD);
  endfunction

endpackage

// File: rtl/nonlinear_resp_if.sv
// Configurator <-> nonlinear responder handshake: request/accept, result
// valid/acknowledge, landmark bookkeeping and the two signed operands.
interface nonlinear_resp_if #(
  parameter int RSA_DW  = 16,
  parameter int ROW_LEN = 10
);
  logic        [2:0]         nonlinear_m_val;
  logic        [2:0]         nonlinear_s_rdy;
  logic        [2:0]         nonlinear_s_val;
  logic        [2:0]         nonlinear_m_rdy;
  logic        [ROW_LEN-1:0] landmark_num;
  logic        [ROW_LEN-1:0] lm_idx;
  logic signed [RSA_DW-1:0]  operand_a;
  logic signed [RSA_DW-1:0]  operand_b;
  logic                      nl_err;

  modport master (
    output nonlinear_m_val, nonlinear_m_rdy, landmark_num, lm_idx,
           operand_a, operand_b,
    input  nonlinear_s_rdy, nonlinear_s_val, nl_err
  );

  modport slave (
    input  nonlinear_m_val, nonlinear_m_rdy, landmark_num, lm_idx,
           operand_a, operand_b,
    output nonlinear_s_rdy, nonlinear_s_val, nl_err
  );
endinterface

// File: rtl/nl_alu.sv
// Combinational result words: w0 = a+b, w1 = a-b, w2 = (a*b)>>>8.
// Define NONLINEAR_SAT_EN to saturate w0/w1; w2 always wraps.
module nl_alu #(
  parameter int RSA_DW = 16
) (
  input  logic signed [RSA_DW-1:0] a,
  input  logic signed [RSA_DW-1:0] b,
  output logic        [RSA_DW-1:0] w0,
  output logic        [RSA_DW-1:0] w1,
  output logic        [RSA_DW-1:0] w2
);

  logic signed [2*RSA_DW-1:0] prod;

`ifdef NONLINEAR_SAT_EN
  logic signed [RSA_DW:0] sum;
  logic signed [RSA_DW:0] diff;

  // Overflow shows up as the two top bits of the widened result disagreeing.
  function automatic logic [RSA_DW-1:0] sat(input logic [RSA_DW:0] v);
    if (v[RSA_DW] == v[RSA_DW-1]) return v[RSA_DW-1:0];
    else if (v[RSA_DW])           return {1'b1, {(RSA_DW-1){1'b0}}};
    else                          return {1'b0, {(RSA_DW-1){1'b1}}};
  endfunction
`endif

  // NOTE: every always_comb output is assigned on every path, so no latches.
  always_comb begin
    prod = a * b;
    w2   = RSA_DW'(prod >>> 8);
`ifdef NONLINEAR_SAT_EN
    sum  = {a[RSA_DW-1], a} + {b[RSA_DW-1], b};
    diff = {a[RSA_DW-1], a} - {b[RSA_DW-1], b};
    w0   = sat(sum);
    w1   = sat(diff);
`else
    w0   = a + b;
    w1   = a - b;
`endif
  end

endmodule

// File: rtl/nonlinear_resp.sv
// Nonlinear responder: accepts a one-hot stage job, waits CALC_LAT cycles,
// streams result words into the temp buffer, then holds s_val until acked.
module nonlinear_resp
  import ekf_pkg::*;
#(
  parameter int RSA_DW   = 16,
  parameter int TB_AW    = 12,
  parameter int ROW_LEN  = 10,
  parameter int CALC_LAT = 4
) (
  input  logic                clk,
  input  logic                sys_rst,
  nonlinear_resp_if.slave     bus,
  output logic                TB_wea,
  output logic [TB_AW-1:0]    TB_addra,
  output logic [RSA_DW-1:0]   TB_dina
);

  localparam int CW = (CALC_LAT > 1) ? $clog2(CALC_LAT) : 1;

  nl_state_e                state;
  logic [2:0]               stage_q;
  logic signed [RSA_DW-1:0] a_q;
  logic signed [RSA_DW-1:0] b_q;
  logic [ROW_LEN-1:0]       lm_idx_q;
  logic                     reject_q;
  logic [CW-1:0]            cnt;
  logic [1:0]               widx;
  logic [2:0]               s_val_q;
  logic                     nl_err_q;

  logic [RSA_DW-1:0]        w0, w1, w2;
  logic                     accept;
  logic                     reject_d;
  logic [1:0]               last_idx;
  logic [TB_AW-1:0]         base;

  nl_alu #(.RSA_DW(RSA_DW)) u_alu (
    .a  (a_q),
    .b  (b_q),
    .w0 (w0),
    .w1 (w1),
    .w2 (w2)
  );

  always_comb begin
    bus.nonlinear_s_rdy = 3'b000;
    if (state == IDLE && is_onehot3(bus.nonlinear_m_val))
      bus.nonlinear_s_rdy = bus.nonlinear_m_val;
    accept   = |(bus.nonlinear_m_val & bus.nonlinear_s_rdy);
    reject_d = ((bus.nonlinear_m_val == STG_NEW) && (bus.lm_idx != bus.landmark_num)) ||
               ((bus.nonlinear_m_val == STG_UPD) && (bus.lm_idx >= bus.landmark_num));
    last_idx = (stage_q == STG_PRD) ? 2'(WORDS_PRD - 1) : 2'(WORDS_LM - 1);
    base     = (stage_q == STG_PRD) ? TB_AW'(BASE_PRD)
                                    : TB_AW'(BASE_LM) + (TB_AW'(lm_idx_q) << 1);
  end

  assign bus.nonlinear_s_val = s_val_q;
  assign bus.nl_err          = nl_err_q;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state    <= IDLE;
      stage_q  <= 3'b000;
      a_q      <= '0;
      b_q      <= '0;
      lm_idx_q <= '0;
      reject_q <= 1'b0;
      cnt      <= '0;
      widx     <= '0;
      s_val_q  <= 3'b000;
      nl_err_q <= 1'b0;
      TB_wea   <= 1'b0;
      TB_addra <= '0;
      TB_dina  <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          stage_q  <= bus.nonlinear_m_val;
          a_q      <= bus.operand_a;
          b_q      <= bus.operand_b;
          lm_idx_q <= bus.lm_idx;
          reject_q <= reject_d;
          cnt      <= CW'(CALC_LAT - 1);
          state    <= CALC;
        end
        CALC: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (reject_q) begin
            s_val_q  <= stage_q;
            nl_err_q <= 1'b1;
            state    <= DONE;
          end else begin
            TB_wea   <= 1'b1;
            TB_addra <= base;
            TB_dina  <= w0;
            widx     <= '0;
            state    <= WRITE;
          end
        end
        WRITE: begin
          if (widx == last_idx) begin
            TB_wea  <= 1'b0;
            s_val_q <= stage_q;
            state   <= DONE;
          end else begin
            widx     <= widx + 1'b1;
            TB_addra <= TB_addra + 1'b1;
            TB_dina  <= (widx == 2'd0) ? w1 : w2;
          end
        end
        DONE: if (|(s_val_q & bus.nonlinear_m_rdy)) begin
          s_val_q  <= 3'b000;
          nl_err_q <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nonlinear_resp.sv
// Directed bench for nonlinear_resp: PRD/NEW/UPD jobs, illegal requests,
// held acknowledge, saturation/wrap and reset during a write burst.
module tb_nonlinear_resp;

  logic              clk = 1'b0;
  logic              sys_rst = 1'b0;
  logic              tb_wea;
  logic [11:0]       tb_addra;
  logic [15:0]       tb_dina;
  int                n_cmp = 0;
  int                n_err = 0;

  nonlinear_resp_if bus ();

  nonlinear_resp #(
    .RSA_DW(16), .TB_AW(12), .ROW_LEN(10), .CALC_LAT(4)
  ) dut (
    .clk      (clk),
    .sys_rst  (sys_rst),
    .bus      (bus),
    .TB_wea   (tb_wea),
    .TB_addra (tb_addra),
    .TB_dina  (tb_dina)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Present a request in the current IDLE cycle T, confirm s_rdy, and
  // return at the negedge of T+1 with the request withdrawn.
  task automatic accept_job(input logic [2:0] stg, input logic [15:0] a, input logic [15:0] b);
    bus.nonlinear_m_val = stg;
    bus.operand_a       = a;
    bus.operand_b       = b;
    #1 check("s_rdy_accept", bus.nonlinear_s_rdy, stg);
    tick();
    bus.nonlinear_m_val = 3'b000;
  endtask

  task automatic check_write(input string tag, input logic [11:0] addr, input logic [15:0] data);
    check({tag, "_wea"}, tb_wea, 1'b1);
    check({tag, "_addr"}, tb_addra, addr);
    check({tag, "_data"}, tb_dina, data);
  endtask

  initial begin
    bus.nonlinear_m_val = 3'b000;
    bus.nonlinear_m_rdy = 3'b000;
    bus.landmark_num    = '0;
    bus.lm_idx          = '0;
    bus.operand_a       = '0;
    bus.operand_b       = '0;

    // Reset state
    tick();
    check("rst_s_val", bus.nonlinear_s_val, 3'b000);
    check("rst_nl_err", bus.nl_err, 1'b0);
    check("rst_wea", tb_wea, 1'b0);
    check("rst_addra", tb_addra, 12'h000);
    check("rst_dina", tb_dina, 16'h0000);
    sys_rst = 1'b1;
    tick();

    // Illegal requests are never accepted
    bus.nonlinear_m_val = 3'b011;
    #1 check("s_rdy_011", bus.nonlinear_s_rdy, 3'b000);
    tick();
    bus.nonlinear_m_val = 3'b111;
    #1 check("s_rdy_111", bus.nonlinear_s_rdy, 3'b000);
    tick();

    // PRD job, second request during CALC ignored, ack withheld 10 cycles
    accept_job(3'b001, 16'h0200, 16'h0300);
    bus.nonlinear_m_val = 3'b001;
    #1 check("s_rdy_calc", bus.nonlinear_s_rdy, 3'b000);
    check("prd_calc_wea", tb_wea, 1'b0);
    tick();
    bus.nonlinear_m_val = 3'b000;
    repeat (3) tick();
    check_write("prd_w0", 12'd0, 16'h0500);
    tick();
    check_write("prd_w1", 12'd1, 16'hFF00);
    tick();
    check_write("prd_w2", 12'd2, 16'h0600);
    tick();
    check("prd_wea_off", tb_wea, 1'b0);
    check("prd_nl_err", bus.nl_err, 1'b0);
    for (int i = 0; i < 10; i++) begin
      check("prd_s_val_hold", bus.nonlinear_s_val, 3'b001);
      if (i < 9) tick();
    end
    bus.nonlinear_m_rdy = 3'b001;
    tick();
    bus.nonlinear_m_rdy = 3'b000;
    check("prd_s_val_clr", bus.nonlinear_s_val, 3'b000);
    check("prd_no_extra_wr", tb_wea, 1'b0);
    tick();
    check("prd_single_job", bus.nonlinear_s_val, 3'b000);

    // NEW job with m_rdy held from before DONE
    bus.landmark_num    = 10'd2;
    bus.lm_idx          = 10'd2;
    bus.nonlinear_m_rdy = 3'b010;
    accept_job(3'b010, 16'h0200, 16'h0300);
    repeat (4) tick();
    check_write("new_w0", 12'd7, 16'h0500);
    tick();
    check_write("new_w1", 12'd8, 16'hFF00);
    tick();
    check("new_wea_off", tb_wea, 1'b0);
    check("new_s_val", bus.nonlinear_s_val, 3'b010);
    check("new_nl_err", bus.nl_err, 1'b0);
    tick();
    check("new_s_val_clr", bus.nonlinear_s_val, 3'b000);
    bus.nonlinear_m_rdy = 3'b000;

    // UPD with lm_idx out of range: rejected, no writes
    bus.landmark_num = 10'd5;
    bus.lm_idx       = 10'd5;
    accept_job(3'b100, 16'h0200, 16'h0300);
    for (int i = 0; i < 4; i++) begin
      check("upd_no_wea", tb_wea, 1'b0);
      check("upd_no_s_val", bus.nonlinear_s_val, 3'b000);
      tick();
    end
    check("upd_wea", tb_wea, 1'b0);
    check("upd_s_val", bus.nonlinear_s_val, 3'b100);
    check("upd_nl_err", bus.nl_err, 1'b1);
    bus.nonlinear_m_rdy = 3'b100;
    tick();
    bus.nonlinear_m_rdy = 3'b000;
    check("upd_s_val_clr", bus.nonlinear_s_val, 3'b000);
    check("upd_err_clr", bus.nl_err, 1'b0);

    // NEW with lm_idx != landmark_num: rejected
    bus.landmark_num = 10'd3;
    bus.lm_idx       = 10'd2;
    accept_job(3'b010, 16'h0001, 16'h0001);
    repeat (4) tick();
    check("new_rej_wea", tb_wea, 1'b0);
    check("new_rej_s_val", bus.nonlinear_s_val, 3'b010);
    check("new_rej_err", bus.nl_err, 1'b1);
    bus.nonlinear_m_rdy = 3'b010;
    tick();
    bus.nonlinear_m_rdy = 3'b000;

    // Positive overflow
    accept_job(3'b001, 16'h7FFF, 16'h0001);
    repeat (4) tick();
`ifdef NONLINEAR_SAT_EN
    check_write("ovf_w0", 12'd0, 16'h7FFF);
`else
    check_write("ovf_w0", 12'd0, 16'h8000);
`endif
    tick();
    check_write("ovf_w1", 12'd1, 16'h7FFE);
    tick();
    check_write("ovf_w2", 12'd2, 16'h007F);
    tick();
    bus.nonlinear_m_rdy = 3'b001;
    tick();
    bus.nonlinear_m_rdy = 3'b000;

    // Negative overflow on w1, negative product on w2
    accept_job(3'b001, 16'h8000, 16'h0001);
    repeat (4) tick();
    check_write("neg_w0", 12'd0, 16'h8001);
    tick();
`ifdef NONLINEAR_SAT_EN
    check_write("neg_w1", 12'd1, 16'h8000);
`else
    check_write("neg_w1", 12'd1, 16'h7FFF);
`endif
    tick();
    check_write("neg_w2", 12'd2, 16'hFF80);
    tick();
    bus.nonlinear_m_rdy = 3'b001;
    tick();
    bus.nonlinear_m_rdy = 3'b000;

    // Reset in WRITE after word 1
    accept_job(3'b001, 16'h0200, 16'h0300);
    repeat (5) tick();
    check_write("rst_mid_w1", 12'd1, 16'hFF00);
    sys_rst = 1'b0;
    #1 check("rst_mid_wea", tb_wea, 1'b0);
    check("rst_mid_addra", tb_addra, 12'h000);
    tick();
    sys_rst = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      check("abort_no_wea", tb_wea, 1'b0);
      check("abort_no_s_val", bus.nonlinear_s_val, 3'b000);
    end
    bus.nonlinear_m_val = 3'b100;
    #1 check("abort_idle_rdy", bus.nonlinear_s_rdy, 3'b100);
    bus.nonlinear_m_val = 3'b000;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/nonlinear_resp.md
NONLINEAR_RESP -- requirements
Module: nonlinear_resp

Interface
REQ-001 Parameters SHALL be (name, default, meaning): RSA_DW, 16, data word width; TB_AW, 12, temp-buffer address width; ROW_LEN, 10, landmark index width; CALC_LAT, 4, compute latency in cycles (>=1).
REQ-002 clk  in  1  system clock; all state updates on its rising edge.
REQ-003 sys_rst  in  1  asynchronous, active-low reset.
REQ-004 nonlinear_m_val  in  3  one-hot stage request from the configurator (001 PRD, 010 NEW, 100 UPD).
REQ-005 nonlinear_s_rdy  out  3  request-accept, mirrors the accepted stage bit.
REQ-006 nonlinear_s_val  out  3  result-valid, stage bit of the finished job.
REQ-007 nonlinear_m_rdy  in  3  configurator acknowledge of the result.
REQ-008 landmark_num  in  ROW_LEN  current landmark count; lm_idx  in  ROW_LEN  target landmark.
REQ-009 operand_a, operand_b  in  RSA_DW each  signed operands, sampled at accept.
REQ-010 TB_wea  out  1, TB_addra  out  TB_AW, TB_dina  out  RSA_DW  temp-buffer write port A.
REQ-011 nl_err  out  1  set with s_val when the job was rejected.

Function
REQ-012 FSM states SHALL be IDLE, CALC, WRITE, DONE.
REQ-013 In IDLE, nonlinear_s_rdy SHALL equal nonlinear_m_val combinationally when m_val is one-hot, else 0; it SHALL be 0 in all other states.
REQ-014 Accept = (m_val & s_rdy) != 0; on accept latch stage, operands, lm_idx and go to CALC.
REQ-015 Non-one-hot or zero m_val SHALL be ignored; m_val while not in IDLE SHALL be ignored.
REQ-016 CALC SHALL last exactly CALC_LAT cycles (down-counter), then go to WRITE.
REQ-017 Result words: w0 = a+b, w1 = a-b, w2 = (a*b) arithmetic-shift-right 8, low RSA_DW bits; PRD writes w0..w2, NEW/UPD write w0..w1.
REQ-018 Base address: PRD 0; NEW/UPD 3 + 2*lm_idx; word k written to base+k, one word per cycle with TB_wea=1; TB_wea=0 otherwise.
REQ-019 UPD with lm_idx >= landmark_num, or NEW with lm_idx != landmark_num, SHALL skip WRITE (no TB_wea), go to DONE with nl_err=1.
REQ-020 DONE: nonlinear_s_val = latched stage, held until (s_val & m_rdy) != 0, then IDLE next cycle with s_val, nl_err cleared.
REQ-021 m_rdy asserted before DONE SHALL have no effect; m_rdy in the first DONE cycle completes the handshake that cycle.
REQ-022 Latency: accept in cycle T, first write in T+CALC_LAT+1, s_val rises the cycle after the last write.

Reset
REQ-023 Reset SHALL force IDLE and drive s_rdy-related state, s_val=0, nl_err=0, TB_wea=0, TB_addra=0, TB_dina=0, counters 0.
REQ-024 Reset mid-job SHALL abort it: no further TB writes, no s_val for that job after release.

Configuration
REQ-025 NONLINEAR_SAT_EN defined: w0 and w1 SHALL saturate to signed RSA_DW range; undefined: w0 and w1 SHALL wrap modulo 2^RSA_DW. w2 SHALL always wrap.

Structure
REQ-026 Stage one-hot codes, per-stage word counts, and base-address constants SHALL live in the shared package ekf_pkg.
REQ-027 Arithmetic SHALL be a combinational sub-module nl_alu (inputs a, b; outputs w0, w1, w2); FSM, counters and address generation stay in nonlinear_resp.

Verification
REQ-028 PRD, a=0x0200, b=0x0300, CALC_LAT=4 -> writes addr0=0x0500, addr1=0xFF00, addr2=0x0600 at T+5..T+7; s_val=001 at T+8.
REQ-029 NEW, landmark_num=2, lm_idx=2, same operands -> writes addr7=0x0500, addr8=0xFF00; s_val=010, nl_err=0.
REQ-030 UPD, landmark_num=5, lm_idx=5 -> no TB_wea, s_val=100 with nl_err=1 at T+5.
REQ-031 a=0x7FFF, b=0x0001 -> w0=0x7FFF with NONLINEAR_SAT_EN, 0x8000 without.
REQ-032 m_val=011, then m_val=001 during CALC -> both ignored (s_rdy=0), only the first valid job runs; m_rdy held low 10 cycles -> s_val held 10 cycles.
REQ-033 sys_rst low during WRITE after word 1 -> TB_wea=0 immediately, IDLE, no s_val after release.
